// File: rtl/sr_ff_ctrl.sv
// Round-robin sequencer sharing one sr_ff flag cell between NREQ requesters.
// Optional build macro SR_CHECK_EN adds a sticky Q/Qn consistency check on err.
module sr_ff_ctrl #(
    parameter int NREQ      = 4,
    parameter int PULSE_CYC = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NREQ-1:0] req,
    input  logic [NREQ-1:0] op,
    output logic [NREQ-1:0] gnt,
    output logic            busy,
    output logic            S,
    output logic            R,
    input  logic            Q,
    input  logic            Qn,
    output logic            err
);
    // state    | meaning
    // IDLE     | waiting for any req; arbitration happens here
    // DRIVE    | S or R held high for PULSE_CYC cycles
    // SETTLE   | S=R=0, let the flag cell settle (Q/Qn checked here)
    // DONE     | one-cycle gnt to the latched winner, rr_ptr updated

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = (PULSE_CYC > 1) ? $clog2(PULSE_CYC) : 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DRIVE,
        ST_SETTLE,
        ST_DONE
    } state_t;

    state_t          state;
    logic [IW-1:0]   rr_ptr;
    logic [IW-1:0]   win;
    logic [IW-1:0]   win_idx;
    logic            op_lat;
    logic [CW-1:0]   cnt;

    // search starts one past the last winner and wraps
    always_comb begin
        int j;
        logic found;
        win_idx = '0;
        found   = 1'b0;
        for (int i = 1; i <= NREQ; i++) begin
            j = int'(rr_ptr) + i;
            if (j >= NREQ) j = j - NREQ;
            if (!found && req[j]) begin
                win_idx = IW'(j);
                found   = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            rr_ptr <= IW'(NREQ - 1);
            win    <= '0;
            op_lat <= 1'b0;
            cnt    <= '0;
            S      <= 1'b0;
            R      <= 1'b0;
            gnt    <= '0;
            busy   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    gnt <= '0;
                    if (|req) begin
                        win    <= win_idx;
                        op_lat <= op[win_idx];
                        cnt    <= CW'(PULSE_CYC - 1);
                        S      <= op[win_idx];
                        R      <= ~op[win_idx];
                        busy   <= 1'b1;
                        state  <= ST_DRIVE;
                    end
                end
                ST_DRIVE: begin
                    if (cnt == '0) begin
                        S     <= 1'b0;
                        R     <= 1'b0;
                        state <= ST_SETTLE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_SETTLE: begin
                    gnt   <= {{(NREQ-1){1'b0}}, 1'b1} << win;
                    state <= ST_DONE;
                end
                ST_DONE: begin
                    gnt    <= '0;
                    rr_ptr <= win;
                    busy   <= 1'b0;
                    state  <= ST_IDLE;
                end
                default: begin
                    S     <= 1'b0;
                    R     <= 1'b0;
                    gnt   <= '0;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef SR_CHECK_EN
    // sampled on the SETTLE->DONE edge; sticky until reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err <= 1'b0;
        end else if (state == ST_SETTLE && ((Q != op_lat) || (Qn == Q))) begin
            err <= 1'b1;
        end
    end
`else
    logic unused_q;
    assign unused_q = Q ^ Qn ^ op_lat;
    assign err      = 1'b0;
`endif

endmodule

// File: doc/sr_ff_ctrl.md
Name: sr_ff_ctrl

Overview:
Sequencing controller and round-robin arbiter that shares one sr_ff flag cell between NREQ requesters. Each requester asks to set or clear the flag. The controller serialises the requests and drives registered, mutually exclusive S/R pulses into sr_ff. It inserts a settle cycle, then returns a one-cycle grant to the winning requester. It sits between requester logic and the sr_ff instance, which it owns exclusively.

Parameters:
NREQ, 4, number of requesters (2..8)
PULSE_CYC, 1, cycles S or R is held high per operation (1..15)

Ports:
clk  input  1  rising-edge clock, shared with sr_ff
rst_n  input  1  asynchronous active-low reset
req  input  NREQ  per-requester request; held high until its gnt bit is seen
op  input  NREQ  per-requester operation, valid while req high: 1=set, 0=clear
gnt  output  NREQ  one-hot, one-cycle completion pulse
busy  output  1  high in any state other than IDLE
S  output  1  set drive to sr_ff, registered
R  output  1  reset drive to sr_ff, registered
Q  input  1  sr_ff Q
Qn  input  1  sr_ff Qn
err  output  1  sticky check error; tied 0 unless SR_CHECK_EN

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous, active-low, on rst_n.
- Reset values: S=0, R=0, gnt=0, busy=0, err=0, state=IDLE, rr_ptr=NREQ-1, cnt=0.
- States:
  - IDLE: if req!=0 at an edge, latch the winner index and op[winner], then go to DRIVE. Load cnt=PULSE_CYC-1. Assert S (op=1) or R (op=0) from the same edge.
  - DRIVE: hold S/R. If cnt=0, go to SETTLE with S=R=0. Otherwise decrement cnt.
  - SETTLE: S=R=0 for one cycle, then go to DONE.
  - DONE: gnt[winner]=1 for this cycle only. Set rr_ptr=winner. Go to IDLE.
- Latency: request sampled at edge k. S/R high for cycles k..k+PULSE_CYC-1. gnt high in cycle k+PULSE_CYC+1. Total occupancy is PULSE_CYC+2 cycles. Back-to-back transactions have a 1-cycle IDLE gap.
- Arbitration: round-robin. Search starts at rr_ptr+1 mod NREQ. After reset req[0] has highest priority. The winner is fixed for the whole transaction.
- Handshake:
  - Requester keeps req and op stable until it samples gnt=1. It drops req or changes op on that edge.
  - req changes during DRIVE/SETTLE/DONE are ignored.
  - A request dropped before gnt is protocol violation; the controller still completes the latched operation and issues gnt.
- Invariants:
  - S and R are never both 1 in any cycle.
  - gnt has at most one bit set.
  - gnt is never issued without a preceding S or R pulse.
- No redundancy filtering: a set request when Q=1 still produces the full S pulse and gnt.
- Reset mid-operation: S/R drop combinationally-through-reset immediately. No gnt is issued for the in-flight request. rr_ptr returns to NREQ-1. The requester must hold or re-assert req.
- Q/Qn are sampled only in SETTLE and only with SR_CHECK_EN.

Optional Feature:
SR_CHECK_EN:
- Defined: on the SETTLE->DONE edge, compare Q with the latched op and check Qn==~Q. Any mismatch sets err=1. err is sticky until rst_n. gnt is still issued.
- Undefined: no compare logic; err is constant 0; Q/Qn are unconnected internally.

Test Plan:
1. Reset: rst_n=0 with req=4'b1111 -> S=0, R=0, gnt=0, busy=0, err=0 throughout; no activity until rst_n=1.
2. Single set: PULSE_CYC=1, req=4'b0001, op=4'b0001 at edge k -> S=1 in cycle k only, busy=1 for k..k+2, gnt=4'b0001 in cycle k+2, sr_ff Q=1 afterwards.
3. Conflict: req=4'b0011, op=4'b0001 at same edge -> S pulse then gnt=4'b0001, one IDLE cycle, R pulse then gnt=4'b0010. Final Q=0. S&R never 1 together.
4. Fairness: req=4'b1111 held, each requester drops and re-raises req after its gnt -> grant order 0,1,2,3,0,1.
5. Reset mid-op: PULSE_CYC=4, rst_n low in 2nd DRIVE cycle -> S falls in the same cycle, no gnt, busy=0. After release, the pending req[0] is re-served first.
6. SR_CHECK_EN defined, Q tied 0 by the bench model, set request -> err=1 from DONE cycle onward. gnt still pulses. err stays 1 through further good transactions until rst_n=0.
